// File: rtl/nios2_pio_ctrl.sv
// rtl/nios2_pio_ctrl.sv - Avalon-MM general-purpose I/O controller with edge capture and irq
//
// Purpose: per-bit direction control, atomic set/clear of output bits, synchronised
// input sampling, per-bit edge capture (write-1-to-clear) and a maskable level irq.
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous reset, active high
//   i_address      register word address (0 DATA, 1 DIR, 2 MASK, 3 EDGE, 4 OUTSET, 5 OUTCLR)
//   i_chipselect   slave select
//   i_write_n      write strobe, active low
//   i_writedata    write data; bits above WIDTH ignored
//   o_readdata     combinational read data; bits above WIDTH read 0
//   i_in_port      asynchronous pin inputs
//   o_out_port     output data register
//   o_oe           output enable (direction register, 1 = output)
//   o_irq          level interrupt, active high
module nios2_pio_ctrl #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_address,
  input  logic             i_chipselect,
  input  logic             i_write_n,
  input  logic [31:0]      i_writedata,
  output logic [31:0]      o_readdata,
  input  logic [WIDTH-1:0] i_in_port,
  output logic [WIDTH-1:0] o_out_port,
  output logic [WIDTH-1:0] o_oe,
  output logic             o_irq
);

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_in_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_sel_edge;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd;

  assign w_wr      = i_chipselect & ~i_write_n;
  assign w_wd      = i_writedata[WIDTH-1:0];
  assign w_in_sync = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_in_sync & ~r_prev;
  assign w_fall    = ~w_in_sync & r_prev;

  always_comb begin
    w_sel_edge = w_rise;
    if (EDGE_TYPE == 1)
      w_sel_edge = w_fall;
    else if (EDGE_TYPE == 2)
      w_sel_edge = w_rise | w_fall;
  end

  // Output bits never capture edges; their pins reflect our own drive.
  assign w_det = w_sel_edge & ~r_dir;
  assign w_clr = (w_wr && i_address == 3'd3) ? w_wd : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data_out <= RESET_VALUE[WIDTH-1:0];
      r_dir      <= DIR_RESET[WIDTH-1:0];
      r_mask     <= '0;
      r_edge     <= '0;
      r_prev     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      if (w_wr) begin
        case (i_address)
          3'd0: r_data_out <= w_wd;
          3'd1: r_dir      <= w_wd;
          3'd2: r_mask     <= w_wd;
          3'd4: r_data_out <= r_data_out | w_wd;
          3'd5: r_data_out <= r_data_out & ~w_wd;
          default: ;
        endcase
      end
      // Clear is applied before the set so a same-cycle edge wins over W1C.
      r_edge <= (r_edge & ~w_clr) | w_det;
      r_prev <= w_in_sync;
      r_sync[0] <= i_in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  always_comb begin
    w_rd = '0;
    case (i_address)
      3'd0: w_rd = (r_dir & r_data_out) | (~r_dir & w_in_sync);
      3'd1: w_rd = r_dir;
      3'd2: w_rd = r_mask;
      3'd3: w_rd = r_edge;
      default: w_rd = '0;
    endcase
  end

  assign o_readdata = 32'(w_rd);
  assign o_out_port = r_data_out;
  assign o_oe       = r_dir;
  assign o_irq      = |(r_edge & r_mask);

endmodule
